// File: rtl/mips_harvard_mem_responder.sv
// Instruction ROM / data RAM responder for the Harvard MIPS CPU.
// Paces the CPU with a FETCH -> DWAIT -> EXEC sequence and a one-cycle clk_enable pulse.
module mips_harvard_mem_responder #(
   parameter int          INSTR_WORDS = 1024,
   parameter int          DATA_WORDS  = 1024,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
   parameter logic [31:0] DATA_BASE   = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        clk_enable,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   input  logic        load_valid,
   input  logic        load_sel,
   input  logic [15:0] load_index,
   input  logic [31:0] load_data,
   output logic        fault,
   output logic [31:0] step_count
);

   localparam int IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
   localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

   typedef enum logic [1:0] {FETCH, DWAIT, EXEC} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        clk_enable_q, clk_enable_d;
   logic [31:0] instr_readdata_q, instr_readdata_d;
   logic [31:0] data_readdata_q, data_readdata_d;
   logic        fault_q, fault_d;
   logic [31:0] step_count_q, step_count_d;

   logic [31:0] imem_q [INSTR_WORDS];
   logic [31:0] dmem_q [DATA_WORDS];

   logic [31:0] instr_idx, data_idx;
   logic        instr_ok, data_ok;
   logic        store_en, preload_i_en, preload_d_en;

   // Index arithmetic wraps in 32 bits, so addresses below the base land far out of range.
   assign instr_idx = (instr_address - INSTR_BASE) >> 2;
   assign data_idx  = (data_address - DATA_BASE) >> 2;
   assign instr_ok  = (instr_address[1:0] == 2'b00) && (instr_idx < 32'(INSTR_WORDS));
   assign data_ok   = (data_address[1:0] == 2'b00) && (data_idx < 32'(DATA_WORDS));

   assign preload_i_en = load_valid && !load_sel && ({16'h0, load_index} < 32'(INSTR_WORDS));
   assign preload_d_en = load_valid &&  load_sel && ({16'h0, load_index} < 32'(DATA_WORDS));

   always_comb begin
      state_d          = state_q;
      wait_cnt_d       = wait_cnt_q;
      instr_readdata_d = instr_readdata_q;
      data_readdata_d  = data_readdata_q;
      fault_d          = fault_q;
      step_count_d     = step_count_q;
      store_en         = 1'b0;
      case (state_q)
         FETCH: begin
            instr_readdata_d = instr_ok ? imem_q[instr_idx[IAW-1:0]] : 32'h0;
            if (!instr_ok) fault_d = 1'b1;
            wait_cnt_d = 4'(WAIT_STATES);
            state_d    = DWAIT;
         end
         DWAIT: begin
            if (wait_cnt_q == 4'd0) begin
               if (data_read) begin
                  data_readdata_d = data_ok ? dmem_q[data_idx[DAW-1:0]] : 32'h0;
                  if (!data_ok) fault_d = 1'b1;
               end
               state_d = EXEC;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         EXEC: begin
            step_count_d = step_count_q + 32'd1;
            if (data_write) begin
               if (data_ok) store_en = !reset;
               else         fault_d  = 1'b1;
            end
            if (data_read && data_write) fault_d = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      clk_enable_d = (state_d == EXEC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= FETCH;
         wait_cnt_q       <= 4'd0;
         clk_enable_q     <= 1'b0;
         instr_readdata_q <= 32'h0;
         data_readdata_q  <= 32'h0;
         fault_q          <= 1'b0;
         step_count_q     <= 32'h0;
      end else begin
         state_q          <= state_d;
         wait_cnt_q       <= wait_cnt_d;
         clk_enable_q     <= clk_enable_d;
         instr_readdata_q <= instr_readdata_d;
         data_readdata_q  <= data_readdata_d;
         fault_q          <= fault_d;
         step_count_q     <= step_count_d;
      end
   end

   // Arrays survive reset; the preload write comes last so it wins a same-word collision.
   always_ff @(posedge clk) begin
      if (store_en) dmem_q[data_idx[DAW-1:0]] <= data_writedata;
      if (preload_d_en) dmem_q[load_index[DAW-1:0]] <= load_data;
      if (preload_i_en) imem_q[load_index[IAW-1:0]] <= load_data;
   end

   assign clk_enable     = clk_enable_q;
   assign instr_readdata = instr_readdata_q;
   assign data_readdata  = data_readdata_q;
   assign fault          = fault_q;
   assign step_count     = step_count_q;

endmodule

// File: doc/mips_harvard_mem_responder.md
# mips_harvard_mem_responder

Memory-side responder for the Harvard CPU's instruction and data ports. It holds instruction ROM and data RAM arrays and answers the CPU's fetch, load and store requests. It paces the CPU by driving `clk_enable`, so every CPU step is a fixed multi-cycle access sequence with registered read data. It sits opposite `mips_cpu_harvard` in the testbench and simulation top level, and also provides a preload port for test programs.

## Interface
- `INSTR_WORDS`, 1024: instruction array depth in 32-bit words.
- `DATA_WORDS`, 1024: data array depth in 32-bit words.
- `WAIT_STATES`, 2: extra data-access latency cycles; legal range 0..15.
- `INSTR_BASE`, 32'hBFC00000: byte address of instruction word 0.
- `DATA_BASE`, 32'h00000000: byte address of data word 0.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `clk_enable`  out  1  CPU step enable; high for exactly one cycle per access sequence.
- `instr_address`  in  32  CPU fetch byte address.
- `instr_readdata`  out  32  registered fetch word.
- `data_address`  in  32  CPU data byte address.
- `data_read`  in  1  load request.
- `data_write`  in  1  store request.
- `data_writedata`  in  32  store data.
- `data_readdata`  out  32  registered load word.
- `load_valid`  in  1  preload strobe.
- `load_sel`  in  1  preload target: 0 = instruction array, 1 = data array.
- `load_index`  in  16  preload word index.
- `load_data`  in  32  preload word.
- `fault`  out  1  sticky access-error flag.
- `step_count`  out  32  number of completed EXEC cycles.

## Operation
- FSM states: FETCH, DWAIT, EXEC.
- FETCH, 1 cycle:
  - `clk_enable` = 0.
  - At the edge, `instr_readdata` <= `imem[(instr_address-INSTR_BASE)>>2]`.
  - Next state: DWAIT, with counter <= `WAIT_STATES`.
- DWAIT, `WAIT_STATES`+1 cycles:
  - `clk_enable` = 0.
  - `data_address` is valid here because it depends on the already-latched `instr_readdata`.
  - Counter decrements each cycle.
  - On the edge where counter == 0: `data_readdata` <= `dmem[(data_address-DATA_BASE)>>2]` if `data_read`, otherwise it holds its value. Next state: EXEC.
- EXEC, 1 cycle:
  - `clk_enable` = 1, so the CPU advances at this edge.
  - If `data_write`, then `dmem[idx]` <= `data_writedata` at the same edge.
  - `step_count` increments.
  - Next state: FETCH.
- Address decode:
  - Index = (addr − base) >> 2, computed in 32-bit unsigned arithmetic with wrap.
  - In range means addr[1:0] == 0 and index < depth.
- Out-of-range or misaligned access:
  - Reads latch 32'h0.
  - Writes are dropped.
  - `fault` <= 1.
  - Checked only where the access is sampled: instr at the FETCH edge, data read at the last DWAIT edge, data write at the EXEC edge.
- `data_read` and `data_write` both high: both are performed and `fault` <= 1.
- Preload:
  - Accepted on any cycle, including during reset.
  - Writes the selected array at `load_index`.
  - An out-of-range index is ignored and does not set `fault`.
  - Preload and an EXEC store to the same data word in the same cycle: preload wins.
- Array contents are never cleared by `reset`.

## Timing
- Reset values: state = FETCH, `clk_enable` = 0, `instr_readdata` = 0, `data_readdata` = 0, `fault` = 0, `step_count` = 0, wait counter = 0.
- `reset` high overrides any state mid-sequence:
  - No store is committed in a cycle with `reset` high, even in EXEC.
  - Preload is still honoured.
- Sequence period = `WAIT_STATES` + 3 cycles.
- First `clk_enable` pulse occurs `WAIT_STATES` + 3 cycles after the cycle in which `reset` is sampled low.
- Read-data outputs are stable throughout the cycle where `clk_enable` = 1. They change only at FETCH or last-DWAIT edges.
- `step_count` wraps from 32'hFFFFFFFF to 0.
- `fault` clears only on `reset`.

## Test plan
- Reset behaviour, `WAIT_STATES`=2:
  - Stimulus: `reset` 3 cycles, then release.
  - Required: `clk_enable` pattern 0,0,0,0,1 repeating with period 5; `step_count` = 1 after the first pulse.
- Fetch:
  - Stimulus: preload `imem[0]` = 32'h24020005 and hold `instr_address` = 32'hBFC00000.
  - Required: `instr_readdata` = 32'h24020005 from the edge after FETCH, stable during EXEC.
- Store then load:
  - Stimulus: EXEC with `data_write`=1, `data_address`=32'h10, `data_writedata`=32'hDEADBEEF; next sequence `data_read`=1 at the same address.
  - Required: `data_readdata` = 32'hDEADBEEF during the second EXEC.
- Faults:
  - Misaligned `data_address` 32'h13 with `data_write`: `dmem` unchanged, `fault` = 1.
  - Separately, `instr_address` 32'h0: `instr_readdata` = 0, `fault` = 1.
- Reset in EXEC:
  - Stimulus: `reset` asserted exactly in EXEC with `data_write`=1 to 32'h20.
  - Required: `dmem[8]` unchanged, state = FETCH, `step_count` = 0.
- Preload collision, `WAIT_STATES`=0:
  - Stimulus: preload `dmem[4]` = 32'h1 in the same cycle as an EXEC store of 32'h2 to 32'h10.
  - Required: `dmem[4]` = 32'h1; period 3 cycles.
